half_adder_unit: RTL and testbench
==================================

Name:
half_adder_unit

Overview:
- Lane-parallel 1-bit half-adder array; per lane: sum = a XOR b, carry = a AND b.
- Combinational outputs give zero-latency results, for the bit-level slot used in multiplier partial-product compression.
- A registered copy with valid tracking serves pipelined datapaths.
- A saturating counter records accepted operations that produced any carry, for verification and debug.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- CNT_W, 16, width of the carry-event counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  a/b qualify for capture this cycle.
- cnt_clr  input  1  synchronous clear of carry_cnt.
- sum  output  WIDTH  combinational a ^ b.
- carry  output  WIDTH  combinational a & b.
- sum_q  output  WIDTH  registered sum of last accepted operands.
- carry_q  output  WIDTH  registered carry of last accepted operands.
- out_valid  output  1  registered in_valid.
- carry_cnt  output  CNT_W  count of accepted operations with any carry bit set.

Behaviour:
- Combinational path:
  - sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i], for every lane i.
  - No dependence on clk, rst_n, or in_valid; valid during reset.
  - Lanes fully independent; no carry propagation between lanes.
- Truth table per lane (a,b -> sum,carry): 00->00, 10->10, 01->10, 11->01.
- Reset (rst_n low, asynchronous, immediate): sum_q = 0, carry_q = 0, out_valid = 0, carry_cnt = 0. Registers hold reset values while rst_n is low.
- Registered path (rising clk, rst_n high):
  - If in_valid = 1: sum_q <= a ^ b; carry_q <= a & b.
  - If in_valid = 0: sum_q and carry_q hold their values.
  - out_valid <= in_valid every cycle, so results appear one cycle after acceptance.
- Carry counter (rising clk):
  - cnt_clr = 1: carry_cnt <= 0. Clear has priority over increment in the same cycle.
  - Otherwise, if in_valid = 1 and |(a & b) = 1: carry_cnt increments by 1.
  - Saturates at all-ones; no wrap-around.
- Reset mid-operation: a pending capture is discarded, out_valid = 0 on the next edge after release, and the counter restarts from 0.
- Invariant on both paths: sum & carry == 0 lane-wise.
- Outputs are never X once rst_n has been asserted and inputs are known.

Test Plan:
- Combinational sweep, WIDTH=1, 10 ns steps: (a,b) = 00, 10, 01, 11 -> (sum,carry) = 00, 10, 10, 01 immediately on each change, including while rst_n = 0.
- Latency/hold: in_valid=1, a=1, b=1 on one edge, then in_valid=0 with a=0, b=1 -> sum_q=0, carry_q=1, out_valid=1 after the first edge; registers hold and out_valid=0 after the second edge.
- Multi-lane, WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000; after an accepted edge sum_q and carry_q match; carry_cnt=1.
- Counter: three accepted ops with carry plus one without -> carry_cnt=3; cnt_clr together with a carry op -> carry_cnt=0.
- Saturation, CNT_W=2: five accepted carry ops -> carry_cnt stays at 3.
- Async reset: assert rst_n=0 between clock edges after captures -> sum_q, carry_q, out_valid, carry_cnt go to 0 without waiting for a clock edge; combinational sum/carry stay correct.

Source files
------------

// File: rtl/half_adder_unit.sv
// half_adder_unit: lane-parallel half adders with a registered copy and a saturating carry-event counter
module half_adder_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);
  assign sum   = a ^ b;
  assign carry = a & b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
      carry_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        carry_q <= carry;
      end
      // clear wins over increment; the counter sticks at all-ones
      if (cnt_clr)
        carry_cnt <= '0;
      else if (in_valid && |carry && carry_cnt != '1)
        carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_half_adder_unit.sv
// tb_half_adder_unit: randomized and directed checks of half_adder_unit against an arithmetic lane model
module tb_half_adder_unit;
  localparam int W = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  logic clk, rst_n, in_valid, cnt_clr;
  logic [W-1:0] a, b, sum, carry, sum_q, carry_q;
  logic out_valid;
  logic [CW-1:0] carry_cnt;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_sum_q, m_carry_q;
  logic m_ov;
  int m_cnt;

  half_adder_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q),
    .out_valid(out_valid), .carry_cnt(carry_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // each lane adds two bits as integers: low bit is sum, high bit is carry
  function automatic logic [W-1:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = 0; i < W; i++) ref_sum[i] = ((int'(x[i]) + int'(y[i])) % 2) == 1;
  endfunction
  function automatic logic [W-1:0] ref_carry(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = 0; i < W; i++) ref_carry[i] = ((int'(x[i]) + int'(y[i])) / 2) == 1;
  endfunction

  task automatic tick();
    logic [W-1:0] rc;
    rc = ref_carry(a, b);
    m_ov = in_valid;
    if (in_valid) begin
      m_sum_q = ref_sum(a, b);
      m_carry_q = rc;
    end
    if (cnt_clr) m_cnt = 0;
    else if (in_valid && rc != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sum_q = '0; m_carry_q = '0; m_ov = 0; m_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; a = 0; b = 0; in_valid = 0; cnt_clr = 0;
    model_reset();
    #2;
    checks++;
    if ({sum_q, carry_q, out_valid, carry_cnt} !== '0) begin
      errors++;
      $display("FAIL reset regs: got sum_q=%b carry_q=%b ov=%b cnt=%0d want all 0", sum_q, carry_q, out_valid, carry_cnt);
    end
  endtask

  task automatic test_comb_sweep();
    logic [1:0] pat [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [1:0] exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      a = {3'b0, pat[i][1]}; b = {3'b0, pat[i][0]};
      #1;
      checks++;
      if ({sum[0], carry[0]} !== exp[i] || sum[W-1:1] !== '0 || carry[W-1:1] !== '0) begin
        errors++;
        $display("FAIL comb sweep rst_n=%b ab=%b: got sum=%b carry=%b want lane0 %b", rst_n, pat[i], sum, carry, exp[i]);
      end
      #9;
    end
  endtask

  task automatic test_latency_hold();
    a = 4'b0001; b = 4'b0001; in_valid = 1;
    tick();
    checks++;
    if (sum_q !== 4'b0000 || carry_q !== 4'b0001 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency capture: got sum_q=%b carry_q=%b ov=%b want 0000 0001 1", sum_q, carry_q, out_valid);
    end
    a = 4'b0000; b = 4'b0001; in_valid = 0;
    tick();
    checks++;
    if (sum_q !== 4'b0000 || carry_q !== 4'b0001 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency hold: got sum_q=%b carry_q=%b ov=%b want 0000 0001 0", sum_q, carry_q, out_valid);
    end
  endtask

  task automatic test_multilane();
    cnt_clr = 1; in_valid = 0;
    tick();
    cnt_clr = 0;
    a = 4'b1100; b = 4'b1010; in_valid = 1;
    #1;
    checks++;
    if (sum !== 4'b0110 || carry !== 4'b1000) begin
      errors++;
      $display("FAIL multilane comb: got sum=%b carry=%b want 0110 1000", sum, carry);
    end
    tick();
    in_valid = 0;
    checks++;
    if (sum_q !== 4'b0110 || carry_q !== 4'b1000 || carry_cnt !== 2'd1) begin
      errors++;
      $display("FAIL multilane reg: got sum_q=%b carry_q=%b cnt=%0d want 0110 1000 1", sum_q, carry_q, carry_cnt);
    end
  endtask

  task automatic test_counter();
    cnt_clr = 1; in_valid = 0;
    tick();
    cnt_clr = 0; in_valid = 1;
    a = 4'b0011; b = 4'b0001; tick();
    a = 4'b0101; b = 4'b1010; tick();
    a = 4'b1000; b = 4'b1000; tick();
    a = 4'b1111; b = 4'b0010; tick();
    in_valid = 0;
    checks++;
    if (carry_cnt !== 2'd3) begin
      errors++;
      $display("FAIL counter count: got %0d want 3", carry_cnt);
    end
    cnt_clr = 1; in_valid = 1; a = 4'b1111; b = 4'b1111;
    tick();
    cnt_clr = 0; in_valid = 0;
    checks++;
    if (carry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL counter clear priority: got %0d want 0", carry_cnt);
    end
    a = 4'b0001; b = 4'b0001;
    tick();
    checks++;
    if (carry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL counter needs in_valid: got %0d want 0", carry_cnt);
    end
  endtask

  task automatic test_saturation();
    in_valid = 1; a = 4'b0100; b = 4'b0110;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 0;
    checks++;
    if (carry_cnt !== 2'd3) begin
      errors++;
      $display("FAIL saturation: got %0d want 3", carry_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      a = W'($urandom); b = W'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (sum !== ref_sum(a, b) || carry !== ref_carry(a, b) || (sum & carry) !== '0) begin
        errors++;
        $display("FAIL random comb %0d a=%b b=%b: got %b/%b want %b/%b", n, a, b, sum, carry, ref_sum(a, b), ref_carry(a, b));
      end
      tick();
      checks++;
      if (sum_q !== m_sum_q || carry_q !== m_carry_q || out_valid !== m_ov || int'(carry_cnt) != m_cnt || carry_cnt === 'x) begin
        errors++;
        $display("FAIL random reg %0d: got %b %b %b %0d want %b %b %b %0d", n, sum_q, carry_q, out_valid, carry_cnt, m_sum_q, m_carry_q, m_ov, m_cnt);
      end
    end
    cnt_clr = 0;
  endtask

  task automatic test_async_reset();
    in_valid = 1; a = 4'b1011; b = 4'b1001;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if ({sum_q, carry_q, out_valid, carry_cnt} !== '0) begin
      errors++;
      $display("FAIL async reset: got sum_q=%b carry_q=%b ov=%b cnt=%0d want all 0", sum_q, carry_q, out_valid, carry_cnt);
    end
    checks++;
    if (sum !== 4'b0010 || carry !== 4'b1001) begin
      errors++;
      $display("FAIL comb in reset: got sum=%b carry=%b want 0010 1001", sum, carry);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({sum_q, carry_q, out_valid, carry_cnt} !== '0) begin
      errors++;
      $display("FAIL reset hold over edge: got sum_q=%b carry_q=%b ov=%b cnt=%0d want all 0", sum_q, carry_q, out_valid, carry_cnt);
    end
    rst_n = 1; in_valid = 0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || carry_cnt !== 2'd0 || sum_q !== '0) begin
      errors++;
      $display("FAIL after release: got ov=%b cnt=%0d sum_q=%b want 0 0 0000", out_valid, carry_cnt, sum_q);
    end
    in_valid = 1; a = 4'b0001; b = 4'b0001;
    tick();
    in_valid = 0;
    checks++;
    if (carry_cnt !== 2'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart count: got cnt=%0d ov=%b want 1 1", carry_cnt, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_comb_sweep();
    @(negedge clk);
    rst_n = 1;
    test_comb_sweep();
    @(posedge clk);
    #1;
    test_latency_hold();
    test_multilane();
    test_counter();
    test_saturation();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
